flit_sender: RTL and testbench

Per-VC flit drain and credit-based link transmitter for the DART router datapath. It reads the NVCS show-ahead virtual-channel queues, picks one eligible VC per cycle by round-robin, and pulses `dequeue` on that VC. It registers the selected flit onto the outbound link and tracks downstream buffer credits per VC. It sits between a flit queue's per-VC outputs and the next hop's flit queue input.

---
 rtl/flit_sender.sv | 217 +++++++++++++++++++++
 tb/tb_flit_sender.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_sender.sv
// flit_sender
//   Per-VC flit drain and credit-based link transmitter. Each cycle one
//   eligible VC (head valid, credit available, enable high) is picked by
//   round-robin. The block pulses dequeue for that VC and registers its
//   flit onto the outbound link. One downstream credit counter is kept
//   per VC.
//
// Parameters
//   LOG_NVCS    - log2 of VC count (NVCS = 1 << LOG_NVCS)
//   MAX_CREDITS - downstream buffer depth per VC, reset value of counters
//   CW          - credit counter width, 2^CW > MAX_CREDITS
//
// Ports
//   clock, reset       - clock, async active-low reset
//   enable             - gates new grants; credit returns always accepted
//   flit_in/_valid     - per-VC show-ahead queue heads
//   dequeue            - one-hot pop strobe, combinational in grant cycle
//   flit_tx/_vc/_valid - registered outbound flit, its VC, 1-cycle pulse
//   credit_in/_valid   - returned credit, VC id in low LOG_NVCS bits
//   credits            - per-VC credit counts (debug)
//   error              - sticky credit-overflow flag
//   sent_count         - flits sent (only built with FLIT_SENDER_STATS_EN)
//
// Build option
//   FLIT_SENDER_STATS_EN : when defined, sent_count is a wrapping 16-bit
//   grant counter; otherwise it is tied to 0.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef CREDIT_WIDTH
`define CREDIT_WIDTH 4
`endif

// Per-VC credit counter. dec and inc in the same cycle cancel. An inc at
// MAX_CREDITS with no dec saturates and raises ovf for that cycle.
module flit_sender_credit #(
  parameter int MAX_CREDITS = 4,
  parameter int CW          = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CW'(MAX_CREDITS)) ovf = 1'b1;
      else                           cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      // Never reached with cnt_q == 0: a VC without credit is not eligible.
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= CW'(MAX_CREDITS);
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

module flit_sender #(
  parameter int LOG_NVCS    = 1,
  parameter int MAX_CREDITS = 4,
  parameter int CW          = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [(1<<LOG_NVCS)*`FLIT_WIDTH-1:0] flit_in,
  input  logic [(1<<LOG_NVCS)-1:0]          flit_in_valid,
  output logic [(1<<LOG_NVCS)-1:0]          dequeue,
  output logic [`FLIT_WIDTH-1:0]            flit_tx,
  output logic [LOG_NVCS-1:0]               flit_tx_vc,
  output logic                              flit_tx_valid,
  input  logic [`CREDIT_WIDTH-1:0]          credit_in,
  input  logic                              credit_in_valid,
  output logic [(1<<LOG_NVCS)*CW-1:0]       credits,
  output logic                              error,
  output logic [15:0]                       sent_count
);

  localparam int NVCS = 1 << LOG_NVCS;
  localparam int FW   = `FLIT_WIDTH;

  logic [FW-1:0]             flits [NVCS];
  logic [NVCS-1:0][CW-1:0]   cred;
  logic [NVCS-1:0]           eligible;
  logic [NVCS-1:0]           cr_inc;
  logic [NVCS-1:0]           ovf;
  logic [NVCS-1:0]           dequeue_d;
  logic [LOG_NVCS-1:0]       cr_vc;
  logic [LOG_NVCS-1:0]       grant_vc;
  logic [LOG_NVCS-1:0]       cand;
  logic                      grant_any;

  logic [LOG_NVCS-1:0]       last_q, last_d;
  logic [FW-1:0]             flit_tx_q, flit_tx_d;
  logic [LOG_NVCS-1:0]       flit_tx_vc_q, flit_tx_vc_d;
  logic                      flit_tx_valid_q, flit_tx_valid_d;
  logic                      error_q, error_d;

  // Only the VC id bits of a credit token carry meaning here.
  logic [`CREDIT_WIDTH-1:0]  unused_credit;
  assign unused_credit = credit_in;
  assign cr_vc         = credit_in[LOG_NVCS-1:0];

  // Per-VC slicing, eligibility and credit counters.
  for (genvar i = 0; i < NVCS; i++) begin : g_vc
    assign flits[i]    = flit_in[i*FW +: FW];
    assign eligible[i] = enable && flit_in_valid[i] && (cred[i] != '0);
    assign cr_inc[i]   = credit_in_valid && (cr_vc == LOG_NVCS'(i));

    flit_sender_credit #(
      .MAX_CREDITS (MAX_CREDITS),
      .CW          (CW)
    ) u_credit (
      .clock (clock),
      .reset (reset),
      .dec   (dequeue_d[i]),
      .inc   (cr_inc[i]),
      .cnt   (cred[i]),
      .ovf   (ovf[i])
    );
  end

  // Round-robin: scan last+1 .. last+NVCS (mod NVCS), first eligible wins.
  // The final step wraps back to last itself, so a lone requester that
  // just won can win again.
  always_comb begin
    grant_any = 1'b0;
    grant_vc  = last_q;
    cand      = '0;
    for (int k = 1; k <= NVCS; k++) begin
      cand = last_q + LOG_NVCS'(k);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_vc  = cand;
      end
    end
  end

  // dequeue is forced low while reset is asserted so the queues never pop
  // on stale state.
  always_comb begin
    dequeue_d = '0;
    if (reset && grant_any) dequeue_d[grant_vc] = 1'b1;
  end

  assign dequeue = dequeue_d;

  always_comb begin
    last_d          = last_q;
    flit_tx_d       = flit_tx_q;
    flit_tx_vc_d    = flit_tx_vc_q;
    flit_tx_valid_d = grant_any;
    error_d         = error_q | (|ovf);
    if (grant_any) begin
      last_d       = grant_vc;
      flit_tx_d    = flits[grant_vc];
      flit_tx_vc_d = grant_vc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NVCS-1 so that VC0 has first priority out of reset.
      last_q          <= LOG_NVCS'(NVCS - 1);
      flit_tx_q       <= '0;
      flit_tx_vc_q    <= '0;
      flit_tx_valid_q <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      last_q          <= last_d;
      flit_tx_q       <= flit_tx_d;
      flit_tx_vc_q    <= flit_tx_vc_d;
      flit_tx_valid_q <= flit_tx_valid_d;
      error_q         <= error_d;
    end
  end

  assign flit_tx       = flit_tx_q;
  assign flit_tx_vc    = flit_tx_vc_q;
  assign flit_tx_valid = flit_tx_valid_q;
  assign error         = error_q;
  assign credits       = cred;

`ifdef FLIT_SENDER_STATS_EN
  logic [15:0] sent_count_q, sent_count_d;

  // Wraps naturally from 0xFFFF to 0; grants already imply enable.
  always_comb begin
    sent_count_d = sent_count_q;
    if (grant_any) sent_count_d = sent_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sent_count_q <= 16'd0;
    else        sent_count_q <= sent_count_d;
  end

  assign sent_count = sent_count_q;
`else
  assign sent_count = 16'd0;
`endif

endmodule

// File: tb/tb_flit_sender.sv
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef CREDIT_WIDTH
`define CREDIT_WIDTH 4
`endif

module tb_flit_sender;

  localparam int LOG_NVCS = 1;
  localparam int NVCS     = 2;
  localparam int MAXC     = 4;
  localparam int CW       = 3;
  localparam int FW       = `FLIT_WIDTH;
  localparam int CRW      = `CREDIT_WIDTH;

`ifdef FLIT_SENDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic [NVCS*FW-1:0]   flit_in;
  logic [NVCS-1:0]      flit_in_valid;
  logic [NVCS-1:0]      dequeue;
  logic [FW-1:0]        flit_tx;
  logic [LOG_NVCS-1:0]  flit_tx_vc;
  logic                 flit_tx_valid;
  logic [CRW-1:0]       credit_in;
  logic                 credit_in_valid;
  logic [NVCS*CW-1:0]   credits;
  logic                 error;
  logic [15:0]          sent_count;

  flit_sender #(
    .LOG_NVCS    (LOG_NVCS),
    .MAX_CREDITS (MAXC),
    .CW          (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .flit_in         (flit_in),
    .flit_in_valid   (flit_in_valid),
    .dequeue         (dequeue),
    .flit_tx         (flit_tx),
    .flit_tx_vc      (flit_tx_vc),
    .flit_tx_valid   (flit_tx_valid),
    .credit_in       (credit_in),
    .credit_in_valid (credit_in_valid),
    .credits         (credits),
    .error           (error),
    .sent_count      (sent_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int cred_of(input int i);
    return int'(credits[i*CW +: CW]);
  endfunction

  // Ends just after a rising edge with reset released and inputs idle.
  task automatic do_reset();
    reset           = 1'b0;
    enable          = 1'b0;
    flit_in_valid   = '0;
    credit_in_valid = 1'b0;
    credit_in       = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] vld;
    logic       en;
    logic       cv;
    logic       cvc;
    logic [1:0] deq;
    int         c0;
    int         c1;
    logic       err;
    logic       txv;
    logic       tvc;
  } vec_t;

  vec_t tbl [20];

  localparam logic [FW-1:0] D0 = FW'(32'h0000_A0A0);
  localparam logic [FW-1:0] D1 = FW'(32'h0000_B1B1);

  // Reference model state for the random phase.
  int            m_cred [NVCS];
  int            m_last;
  bit            m_err;
  bit            m_txv;
  int            m_txvc;
  logic [FW-1:0] m_txd;
  logic [15:0]   m_sent;

  initial begin
    // Each row: inputs for one cycle, the dequeue expected in that cycle,
    // and registered outputs observed in that cycle (state before its edge).
    //          vld    en cv cvc deq    c0 c1 err txv tvc
    tbl[0]  = '{2'b01, 1, 0, 0, 2'b01, 4, 4, 0, 0, 0};
    tbl[1]  = '{2'b01, 1, 0, 0, 2'b01, 3, 4, 0, 1, 0};
    tbl[2]  = '{2'b01, 1, 0, 0, 2'b01, 2, 4, 0, 1, 0};
    tbl[3]  = '{2'b01, 1, 0, 0, 2'b01, 1, 4, 0, 1, 0};
    tbl[4]  = '{2'b01, 1, 0, 0, 2'b00, 0, 4, 0, 1, 0};
    tbl[5]  = '{2'b01, 1, 0, 0, 2'b00, 0, 4, 0, 0, 0};
    tbl[6]  = '{2'b01, 1, 1, 0, 2'b00, 0, 4, 0, 0, 0};
    tbl[7]  = '{2'b01, 1, 0, 0, 2'b01, 1, 4, 0, 0, 0};
    tbl[8]  = '{2'b01, 1, 0, 0, 2'b00, 0, 4, 0, 1, 0};
    tbl[9]  = '{2'b00, 1, 1, 0, 2'b00, 0, 4, 0, 0, 0};
    tbl[10] = '{2'b00, 1, 1, 0, 2'b00, 1, 4, 0, 0, 0};
    tbl[11] = '{2'b00, 1, 1, 0, 2'b00, 2, 4, 0, 0, 0};
    tbl[12] = '{2'b00, 1, 1, 0, 2'b00, 3, 4, 0, 0, 0};
    tbl[13] = '{2'b11, 1, 0, 0, 2'b10, 4, 4, 0, 0, 0};
    tbl[14] = '{2'b11, 1, 0, 0, 2'b01, 4, 3, 0, 1, 1};
    tbl[15] = '{2'b11, 1, 0, 0, 2'b10, 3, 3, 0, 1, 0};
    tbl[16] = '{2'b11, 1, 0, 0, 2'b01, 3, 2, 0, 1, 1};
    tbl[17] = '{2'b11, 0, 0, 0, 2'b00, 2, 2, 0, 1, 0};
    tbl[18] = '{2'b10, 1, 1, 1, 2'b10, 2, 2, 0, 0, 0};
    tbl[19] = '{2'b00, 1, 0, 0, 2'b00, 2, 2, 0, 1, 1};

    // ---- reset defaults, dequeue forced low during reset ----
    flit_in         = {D1, D0};
    reset           = 1'b0;
    enable          = 1'b1;
    flit_in_valid   = 2'b11;
    credit_in_valid = 1'b0;
    credit_in       = '0;
    #2;
    chk("dequeue_in_reset", 64'(dequeue), 64'(0));
    do_reset();
    @(negedge clock);
    chk("rst_dequeue", 64'(dequeue), 64'(0));
    chk("rst_txv", 64'(flit_tx_valid), 64'(0));
    chk("rst_tx", 64'(flit_tx), 64'(0));
    chk("rst_txvc", 64'(flit_tx_vc), 64'(0));
    chk("rst_cred0", 64'(cred_of(0)), 64'(MAXC));
    chk("rst_cred1", 64'(cred_of(1)), 64'(MAXC));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_sent", 64'(sent_count), 64'(0));
    @(posedge clock); #1;

    // ---- table: exhaustion, credit refill, round-robin, grant+credit ----
    for (int s = 0; s < 20; s++) begin
      flit_in_valid   = tbl[s].vld;
      enable          = tbl[s].en;
      credit_in_valid = tbl[s].cv;
      credit_in       = CRW'($urandom);
      credit_in[0]    = tbl[s].cvc;
      @(negedge clock);
      chk($sformatf("tbl%0d_deq", s), 64'(dequeue), 64'(tbl[s].deq));
      chk($sformatf("tbl%0d_c0", s), 64'(cred_of(0)), 64'(tbl[s].c0));
      chk($sformatf("tbl%0d_c1", s), 64'(cred_of(1)), 64'(tbl[s].c1));
      chk($sformatf("tbl%0d_err", s), 64'(error), 64'(tbl[s].err));
      chk($sformatf("tbl%0d_txv", s), 64'(flit_tx_valid), 64'(tbl[s].txv));
      if (tbl[s].txv) begin
        chk($sformatf("tbl%0d_tvc", s), 64'(flit_tx_vc), 64'(tbl[s].tvc));
        chk($sformatf("tbl%0d_tx", s), 64'(flit_tx), 64'(tbl[s].tvc ? D1 : D0));
      end
      @(posedge clock); #1;
    end

    // ---- credit overflow, sticky error ----
    do_reset();
    enable          = 1'b1;
    credit_in_valid = 1'b1;
    credit_in       = '0;
    @(posedge clock); #1;
    credit_in_valid = 1'b0;
    @(negedge clock);
    chk("ovf_cred0", 64'(cred_of(0)), 64'(MAXC));
    chk("ovf_error", 64'(error), 64'(1));
    repeat (10) @(posedge clock);
    #1;
    chk("ovf_error_sticky", 64'(error), 64'(1));

    // ---- reset mid-operation drops in-flight flit ----
    flit_in_valid = 2'b01;
    @(posedge clock); #1;
    chk("mid_txv_before", 64'(flit_tx_valid), 64'(1));
    reset = 1'b0;
    #1;
    chk("mid_txv", 64'(flit_tx_valid), 64'(0));
    chk("mid_dequeue", 64'(dequeue), 64'(0));
    chk("mid_cred0", 64'(cred_of(0)), 64'(MAXC));
    chk("mid_error", 64'(error), 64'(0));

    // ---- randomized run against a behavioural model ----
    do_reset();
    for (int i = 0; i < NVCS; i++) m_cred[i] = MAXC;
    m_last = NVCS - 1;
    m_err  = 0;
    m_txv  = 0;
    m_txvc = 0;
    m_txd  = '0;
    m_sent = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int g;
      int cvc;
      logic [NVCS-1:0] exp_deq;
      flit_in_valid   = NVCS'($urandom);
      enable          = ($urandom_range(0, 7) != 0);
      credit_in_valid = ($urandom_range(0, 2) == 0);
      credit_in       = CRW'($urandom);
      for (int i = 0; i < NVCS; i++) flit_in[i*FW +: FW] = FW'($urandom);
      cvc = int'(credit_in) % NVCS;

      g = -1;
      for (int k = 1; k <= NVCS; k++) begin
        int v;
        v = (m_last + k) % NVCS;
        if (g < 0 && enable && flit_in_valid[v] && m_cred[v] > 0) g = v;
      end
      exp_deq = '0;
      if (g >= 0) exp_deq[g] = 1'b1;

      @(negedge clock);
      chk("rnd_deq", 64'(dequeue), 64'(exp_deq));
      chk("rnd_txv", 64'(flit_tx_valid), 64'(m_txv));
      chk("rnd_tx", 64'(flit_tx), 64'(m_txd));
      chk("rnd_txvc", 64'(flit_tx_vc), 64'(m_txvc));
      for (int i = 0; i < NVCS; i++)
        chk($sformatf("rnd_cred%0d", i), 64'(cred_of(i)), 64'(m_cred[i]));
      chk("rnd_err", 64'(error), 64'(m_err));
      chk("rnd_sent", 64'(sent_count), 64'(STATS ? m_sent : 16'd0));

      for (int i = 0; i < NVCS; i++) begin
        bit dec, inc;
        dec = (g == i);
        inc = credit_in_valid && (cvc == i);
        if (inc && !dec) begin
          if (m_cred[i] == MAXC) m_err = 1;
          else                   m_cred[i]++;
        end else if (dec && !inc) begin
          m_cred[i]--;
        end
      end
      m_txv = (g >= 0);
      if (g >= 0) begin
        m_txvc = g;
        m_txd  = flit_in[g*FW +: FW];
        m_last = g;
        m_sent = m_sent + 16'd1;
      end
      @(posedge clock); #1;
    end

    // ---- stats counter wrap: one grant per cycle, credit returned each cycle ----
    do_reset();
    enable          = 1'b1;
    flit_in_valid   = 2'b01;
    credit_in_valid = 1'b1;
    credit_in       = '0;
    repeat (65535) @(posedge clock);
    #1;
    chk("stats_ffff", 64'(sent_count), 64'(STATS ? 16'hFFFF : 16'd0));
    repeat (2) @(posedge clock);
    #1;
    chk("stats_wrap", 64'(sent_count), 64'(STATS ? 16'd1 : 16'd0));
    chk("stats_cred0", 64'(cred_of(0)), 64'(MAXC));
    chk("stats_error", 64'(error), 64'(0));
    chk("stats_txv", 64'(flit_tx_valid), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
